// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state codes, access encodings and sizing helper for mem_arbiter
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    // Only a 1/256 slice of the address space is populated by default.
    function automatic int mem_entries_default(input int addr_w);
        return (2 ** addr_w) / 256;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request after ptr, modulo NUM_REQ
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        // k = NUM_REQ wraps back to ptr itself, so the last owner is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sharing of one single-port synchronous memory between NUM_REQ requesters
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int MEM_ENTRIES = mem_entries_default(ADDR_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_rd_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    output logic                      mem_enb,
    output logic                      mem_rd_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data_in,
    input  logic [DATA_W-1:0]         mem_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic               lat_rd_wr;
    logic               lat_err;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;
    logic               sel_rd_wr;
    logic               sel_err;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept    = (state == ST_IDLE) && !rst && (|req_valid);
    assign sel_rd_wr = req_rd_wr[grant_idx];
    assign sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    assign sel_err   = (32'(sel_addr) >= 32'(MEM_ENTRIES));

    assign req_ready = accept ? grant : '0;
    assign busy      = (state != ST_IDLE);
    // Gating with rst keeps a reset landing in ISSUE from writing the memory.
    assign mem_enb   = (state == ST_ISSUE) && !rst;
    assign mem_rd_wr = mem_enb ? lat_rd_wr : MEM_RD;
    assign rsp_err   = (state == ST_RESP) && !rst && lat_err;

    always_comb begin
        rsp_valid = '0;
        if (state == ST_RESP && !rst) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            owner       <= '0;
            lat_rd_wr   <= MEM_RD;
            lat_err     <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ptr       <= grant_idx;
                        owner     <= grant_idx;
                        lat_rd_wr <= sel_rd_wr;
                        lat_err   <= sel_err;
                        // Rejected addresses never reach the memory pins.
                        if (!sel_err) begin
                            mem_addr <= sel_addr;
                            if (sel_rd_wr == MEM_WR) begin
                                mem_data_in <= sel_wdata;
                            end
                            state <= ST_ISSUE;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= (lat_rd_wr == MEM_RD) ? ST_RD_WAIT : ST_RESP;
                end
                ST_RD_WAIT: begin
                    rsp_rdata <= mem_data_out;
                    state     <= ST_RESP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural memory and reference model
module tb_mem_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int MEM_ENTRIES = 256;

    typedef struct {
        int                req;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              err;
        logic [DATA_W-1:0] rdata;
        int                lat;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_rd_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      rsp_err;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      busy;
    logic                      mem_enb;
    logic                      mem_rd_wr;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W-1:0]         mem_data_out;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem_arr [MEM_ENTRIES];
    logic [DATA_W-1:0] ref_mem [MEM_ENTRIES];
    logic [DATA_W-1:0] ref_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_ENTRIES (MEM_ENTRIES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd_wr    (req_rd_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .mem_enb      (mem_enb),
        .mem_rd_wr    (mem_rd_wr),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Single-port memory, registered read; output is garbage except after a read issue.
    always @(posedge clk) begin
        if (mem_enb && mem_rd_wr) mem_data_out <= mem_arr[mem_addr[7:0]];
        else                      mem_data_out <= $urandom;
        if (mem_enb && !mem_rd_wr) mem_arr[mem_addr[7:0]] <= mem_data_in;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic rd,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[r]                  = v;
        req_rd_wr[r]                  = rd;
        req_addr[r*ADDR_W +: ADDR_W]  = a;
        req_wdata[r*DATA_W +: DATA_W] = d;
    endtask

    // Reference: range rule, latency per kind, memory as an array, read data sticky.
    function automatic vec_t model(input int r, input logic rd,
                                   input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        vec_t v;
        v.req   = r;
        v.rd    = rd;
        v.addr  = a;
        v.wdata = d;
        v.err   = (int'(a) >= MEM_ENTRIES);
        v.lat   = v.err ? 1 : (rd ? 3 : 2);
        if (!v.err && rd)  ref_rdata = ref_mem[a[7:0]];
        if (!v.err && !rd) ref_mem[a[7:0]] = d;
        v.rdata = ref_rdata;
        return v;
    endfunction

    task automatic accept_one(input int r, input logic rd, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input string tag, output bit ok);
        int w;
        @(negedge clk);
        set_req(r, 1'b1, rd, a, d);
        #1;
        w = 0;
        while (!req_ready[r] && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check({tag, " ready"}, 64'(req_ready), 64'(1) << r);
        ok = req_ready[r];
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int lat;
        int enb_cnt;
        bit done;
        bit ok;
        accept_one(v.req, v.rd, v.addr, v.wdata, tag, ok);
        if (!ok) begin
            req_valid = '0;
            return;
        end
        lat = 0;
        enb_cnt = 0;
        done = 1'b0;
        while (!done && lat < 8) begin
            @(negedge clk);
            if (lat == 0) req_valid[v.req] = 1'b0;
            lat++;
            #1;
            if (mem_enb) begin
                enb_cnt++;
                check({tag, " mem_rd_wr"}, 64'(mem_rd_wr), 64'(v.rd));
                check({tag, " mem_addr"}, 64'(mem_addr), 64'(v.addr));
                if (!v.rd) check({tag, " mem_data_in"}, 64'(mem_data_in), 64'(v.wdata));
            end
            if (rsp_valid != '0) done = 1'b1;
        end
        check({tag, " latency"}, 64'(lat), 64'(v.lat));
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1) << v.req);
        check({tag, " rsp_err"}, 64'(rsp_err), 64'(v.err));
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.rdata));
        check({tag, " enb pulses"}, 64'(enb_cnt), v.err ? 64'(0) : 64'(1));
        @(negedge clk);
        #1;
        check({tag, " rsp pulse width"}, 64'(rsp_valid), 64'(0));
        check({tag, " idle after rsp"}, 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_rdata = '0;
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int   q_next[2];
        int   acc_who[$];
        int   acc_cyc[$];
        bit   busy_h[16];
        int   r0_hits;
        int   lows;
        bit   ok;

        for (int i = 0; i < MEM_ENTRIES; i++) begin
            mem_arr[i] = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        ref_rdata = '0;
        req_valid = '0;
        req_rd_wr = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset with both requesters asking: nothing accepted, no memory activity.
        rst = 1'b1;
        set_req(0, 1'b1, 1'b1, 16'h0001, 32'h0);
        set_req(1, 1'b1, 1'b0, 16'h0002, 32'h1111_2222);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            check("reset req_ready", 64'(req_ready), 64'(0));
            check("reset mem_enb", 64'(mem_enb), 64'(0));
        end
        check("reset rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset rsp_err", 64'(rsp_err), 64'(0));
        check("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset mem_rd_wr", 64'(mem_rd_wr), 64'(1));
        check("reset mem_addr", 64'(mem_addr), 64'(0));
        check("reset mem_data_in", 64'(mem_data_in), 64'(0));
        req_valid = '0;
        rst = 1'b0;

        // Directed vectors; expectations worked out by hand.
        tbl[0] = '{0, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 2};
        tbl[1] = '{0, 1'b1, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF, 3};
        tbl[2] = '{1, 1'b1, 16'h0100, 32'h0,        1'b1, 32'hDEADBEEF, 1};
        tbl[3] = '{1, 1'b0, 16'h00FF, 32'h1234_5678, 1'b0, 32'hDEADBEEF, 2};
        tbl[4] = '{1, 1'b1, 16'h00FF, 32'h0,        1'b0, 32'h1234_5678, 3};
        tbl[5] = '{0, 1'b1, 16'hFFFF, 32'h0,        1'b1, 32'h1234_5678, 1};
        tbl[6] = '{0, 1'b0, 16'h0100, 32'h5555_AAAA, 1'b1, 32'h1234_5678, 1};
        tbl[7] = '{0, 1'b1, 16'h0000, 32'h0,        1'b0, 32'hC0DE_0000, 3};
        tbl[8] = '{1, 1'b0, 16'h0000, 32'hA5A5_A5A5, 1'b0, 32'hC0DE_0000, 2};
        tbl[9] = '{1, 1'b1, 16'h0000, 32'h0,        1'b0, 32'hA5A5_A5A5, 3};
        for (int i = 0; i < 10; i++) begin
            void'(model(tbl[i].req, tbl[i].rd, tbl[i].addr, tbl[i].wdata));
            do_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Both requesters hold valid for four writes each.
        do_reset();
        q_next[0] = 0;
        q_next[1] = 0;
        for (int c = 0; c < 80 && (q_next[0] < 4 || q_next[1] < 4); c++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (q_next[j] < 4)
                    set_req(j, 1'b1, 1'b0, 16'(16'h20 + j*8 + q_next[j]), 32'hA000_0000 | 32'(j*256 + q_next[j]));
                else
                    req_valid[j] = 1'b0;
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                if (req_ready[j]) begin
                    acc_who.push_back(j);
                    acc_cyc.push_back(c);
                    ref_mem[8'(8'h20 + j*8 + q_next[j])] = 32'hA000_0000 | 32'(j*256 + q_next[j]);
                    q_next[j]++;
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
        check("rr accept count", 64'(acc_who.size()), 64'(8));
        for (int k = 0; k < acc_who.size(); k++) begin
            check($sformatf("rr order %0d", k), 64'(acc_who[k]), 64'(k % 2));
            if (k > 0) check($sformatf("rr spacing %0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(3));
        end
        for (int j = 0; j < 2; j++) begin
            for (int q = 0; q < 4; q++) begin
                v = model(1 - j, 1'b1, 16'(16'h20 + j*8 + q), 32'h0);
                do_txn(v, $sformatf("rr readback %0d.%0d", j, q));
            end
        end

        // Read aborted by reset in RD_WAIT.
        accept_one(0, 1'b1, 16'h0010, 32'h0, "abort rd", ok);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort rd rsp_valid in reset", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        ref_rdata = '0;
        #1;
        check("abort rd no rsp", 64'(rsp_valid), 64'(0));
        check("abort rd busy", 64'(busy), 64'(0));
        check("abort rd rdata cleared", 64'(rsp_rdata), 64'(0));
        v = model(1, 1'b1, 16'h0010, 32'h0);
        do_txn(v, "after abort rd");

        // Write aborted by reset in ISSUE must not reach memory.
        accept_one(0, 1'b0, 16'h0010, 32'h0BAD_F00D, "abort wr", ok);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("abort wr mem_enb", 64'(mem_enb), 64'(0));
        check("abort wr rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        ref_rdata = '0;
        v = model(0, 1'b1, 16'h0010, 32'h0);
        do_txn(v, "after abort wr");

        // Requester 1 alone, continuous reads.
        acc_cyc.delete();
        r0_hits = 0;
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 16'h0010, 32'h0);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            busy_h[c] = busy;
            if (rsp_valid[0]) r0_hits++;
            if (rsp_valid[1]) check($sformatf("b2b rdata c%0d", c), 64'(rsp_rdata), 64'(ref_mem[8'h10]));
            if (req_ready[1]) acc_cyc.push_back(c);
        end
        @(negedge clk);
        req_valid = '0;
        ref_rdata = ref_mem[8'h10];
        repeat (4) @(negedge clk);
        check("b2b accepts", 64'(acc_cyc.size()), 64'(4));
        check("b2b rsp_valid[0]", 64'(r0_hits), 64'(0));
        for (int k = 1; k < acc_cyc.size(); k++)
            check($sformatf("b2b spacing %0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'(4));
        if (acc_cyc.size() > 0) begin
            lows = 0;
            for (int c = acc_cyc[0]; c <= acc_cyc[acc_cyc.size()-1]; c++) if (!busy_h[c]) lows++;
            check("b2b busy low cycles", 64'(lows), 64'(acc_cyc.size()));
        end

        // Randomised traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [ADDR_W-1:0] a;
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(MEM_ENTRIES, 65535));
            else                           a = 16'($urandom_range(0, MEM_ENTRIES - 1));
            v = model(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            do_txn(v, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
